// File: rtl/bin_ascii_seq.sv
// Sequential binary-to-ASCII converter: double-dabble, one bit per clock, start/busy/done handshake.
// Optional build macro LEADING_ZERO_BLANK_EN replaces leading-zero digits with ASCII space.
module bin_ascii_seq #(
   parameter int IN_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [IN_W-1:0] binIn,
   output logic            busy,
   output logic            done,
   output logic [6:0]      AC,
   output logic [6:0]      AD,
   output logic [6:0]      AU
);

   typedef enum logic {IDLE, CONV} state_t;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] RST_AC = 7'h20;
   localparam logic [6:0] RST_AD = 7'h20;
`else
   localparam logic [6:0] RST_AC = 7'h30;
   localparam logic [6:0] RST_AD = 7'h30;
`endif
   localparam logic [6:0] RST_AU = 7'h30;

   state_t            state_reg, state_next;
   logic [IN_W-1:0]   shift_reg, shift_next;
   logic [11:0]       bcd_reg, bcd_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic [6:0]        ac_reg, ac_next, ad_reg, ad_next, au_reg, au_next;
   logic              done_reg, done_next;
   logic [11:0]       bcd_adj;
   logic [IN_W+11:0]  dabble;
   logic [3:0]        hund, tens, units;

   // Add-3 correction on every BCD nibble before the shift.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
      end
   endgenerate

   assign dabble = {bcd_adj, shift_reg} << 1;
   assign hund   = dabble[IN_W+8 +: 4];
   assign tens   = dabble[IN_W+4 +: 4];
   assign units  = dabble[IN_W   +: 4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         bcd_reg   <= '0;
         cnt_reg   <= '0;
         ac_reg    <= RST_AC;
         ad_reg    <= RST_AD;
         au_reg    <= RST_AU;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         bcd_reg   <= bcd_next;
         cnt_reg   <= cnt_next;
         ac_reg    <= ac_next;
         ad_reg    <= ad_next;
         au_reg    <= au_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      bcd_next   = bcd_reg;
      cnt_next   = cnt_reg;
      ac_next    = ac_reg;
      ad_next    = ad_reg;
      au_next    = au_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               shift_next = binIn;
               bcd_next   = '0;
               cnt_next   = 4'(IN_W);
               state_next = CONV;
            end
         end
         CONV: begin
            shift_next = dabble[IN_W-1:0];
            bcd_next   = dabble[IN_W +: 12];
            cnt_next   = cnt_reg - 4'd1;
            // Last iteration: publish digits taken straight from the final shift.
            if (cnt_reg == 4'd1) begin
               state_next = IDLE;
               done_next  = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
               ac_next = (hund == 4'd0) ? 7'h20 : {3'b011, hund};
               ad_next = (hund == 4'd0 && tens == 4'd0) ? 7'h20 : {3'b011, tens};
`else
               ac_next = {3'b011, hund};
               ad_next = {3'b011, tens};
`endif
               au_next = {3'b011, units};
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg == CONV);
      done = done_reg;
      AC   = ac_reg;
      AD   = ad_reg;
      AU   = au_reg;
   end

endmodule

// File: tb/tb_bin_ascii_seq.sv
// Self-checking bench for bin_ascii_seq: directed and random conversions against a decimal model.
module tb_bin_ascii_seq;
   localparam int IN_W = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            start = 1'b0;
   logic [IN_W-1:0] binIn = '0;
   logic            busy, done;
   logic [6:0]      AC, AD, AU;

   int n_pass = 0;
   int n_total = 0;
   logic [20:0] last_exp;

   bin_ascii_seq #(.IN_W(IN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .binIn(binIn),
      .busy(busy), .done(done), .AC(AC), .AD(AD), .AU(AU)
   );

   always #5 clk = ~clk;

   // Decimal reference: digits by division, optional leading-zero blanking.
   function automatic logic [20:0] ref_ascii(input int v);
      int h, t, u;
      logic [6:0] a, b, c;
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      a = 7'(48 + h);
      b = 7'(48 + t);
      c = 7'(48 + u);
`ifdef LEADING_ZERO_BLANK_EN
      if (h == 0) a = 7'h20;
      if (h == 0 && t == 0) b = 7'h20;
`endif
      return {a, b, c};
   endfunction

   function automatic logic [20:0] rst_ascii();
`ifdef LEADING_ZERO_BLANK_EN
      return {7'h20, 7'h20, 7'h30};
`else
      return {7'h30, 7'h30, 7'h30};
`endif
   endfunction

   task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Called at a negedge; accepts on the next posedge and checks every cycle up to done.
   task automatic run_conv(input int v, input bit hold, input bit poke);
      logic [20:0] exp;
      exp = ref_ascii(v);
      binIn = IN_W'(v);
      start = 1'b1;
      for (int i = 0; i < IN_W; i++) begin
         @(negedge clk);
         if (i == 0) begin
            binIn = IN_W'($urandom);
            if (!hold) start = 1'b0;
         end
         if (poke && i == 2) begin
            start = 1'b1;
            binIn = IN_W'(7);
         end
         if (poke && i == 3) start = 1'b0;
         chk($sformatf("busy_done_conv v=%0d c=%0d", v, i), {19'd0, busy, done}, 21'b10);
         chk($sformatf("hold_digits v=%0d c=%0d", v, i), {AC, AD, AU}, last_exp);
      end
      @(negedge clk);
      chk($sformatf("busy_done_end v=%0d", v), {19'd0, busy, done}, 21'b01);
      chk($sformatf("digits v=%0d", v), {AC, AD, AU}, exp);
      $display("conv v=%0d -> %h %h %h", v, AC, AD, AU);
      last_exp = exp;
   endtask

   initial begin
      last_exp = rst_ascii();
      // Asynchronous reset before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("reset_hs", {19'd0, busy, done}, 21'b00);
      chk("reset_digits", {AC, AD, AU}, rst_ascii());
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_conv(0, 1'b0, 1'b0);
      @(negedge clk);
      chk("done_one_cycle_0", {20'd0, done}, 21'd0);

      run_conv(198, 1'b0, 1'b0);
      run_conv(255, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("no_extra_done c=%0d", i), {20'd0, done}, 21'd0);
         chk($sformatf("ignored_start c=%0d", i), {AC, AD, AU}, ref_ascii(255));
      end

      // Back-to-back sweep with start held high.
      for (int v = 0; v < (1 << IN_W); v++) run_conv(v, 1'b1, 1'b0);
      start = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 40; i++) run_conv(int'($urandom_range(0, (1 << IN_W) - 1)), 1'b0, 1'b0);

      // Reset during the 4th CONV cycle, asserted mid-cycle.
      binIn = IN_W'(123);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midconv_reset_hs", {19'd0, busy, done}, 21'b00);
      chk("midconv_reset_digits", {AC, AD, AU}, rst_ascii());
      last_exp = rst_ascii();
      for (int i = 0; i < IN_W; i++) begin
         @(negedge clk);
         if (i == 1) rst_n = 1'b1;
         chk($sformatf("no_done_after_abort c=%0d", i), {19'd0, busy, done}, 21'b00);
         chk($sformatf("abort_digits c=%0d", i), {AC, AD, AU}, rst_ascii());
      end
      run_conv(123, 1'b0, 1'b0);

      run_conv(7, 1'b0, 1'b0);
      run_conv(40, 1'b0, 1'b0);
      run_conv(0, 1'b0, 1'b0);
      run_conv(105, 1'b0, 1'b0);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bin_ascii_seq.md
Name: bin_ascii_seq

Overview:
Sequential binary-to-ASCII converter: the inverse of the ASCII-digit-to-binary front end of the ASCII adder. Accepts an unsigned binary result (e.g. adder sum 0..198) and produces three 7-bit ASCII decimal digits: hundreds, tens and units. Uses iterative double-dabble (shift-and-add-3), one bit per clock, with a start/busy/done handshake. Sits between the binary adder and the display/UART output stage.

Parameters:
IN_W, 8, width of binIn; legal range 4..9 (maximum 511 fits in three digits); conversion takes IN_W iterations.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request, sampled only in IDLE
binIn  input  IN_W  unsigned binary value, captured on the accepting edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new digits are valid
AC  output  7  ASCII hundreds digit
AD  output  7  ASCII tens digit
AU  output  7  ASCII units digit

Behaviour:
- Reset (rst_n=0, asynchronous, no clock required): state=IDLE, busy=0, done=0, AC=AD=AU=7'h30 ('0'). Internal shift and BCD registers and the iteration counter cleared.
- States:
  - IDLE: start=1 at edge k -> capture binIn into the shift register, clear the BCD registers, load counter=IN_W, go to CONV, busy=1.
  - CONV: each edge applies add-3 to every BCD nibble >=5, then shifts {BCD_hundreds, BCD_tens, BCD_units, shift} left by 1 and decrements the counter. On the edge where counter reaches 0 (edge k+IN_W; k+8 at default): AC/AD/AU <= 7'h30 | {3'b000, nibble}, done=1, busy=0, go to IDLE.
- Latency: done high during the cycle following edge k+IN_W, i.e. IN_W cycles after the accepting edge. Earliest next accept is edge k+IN_W+1, so throughput is one conversion per IN_W+1 cycles.
- done: exactly one cycle, then 0. Never asserted without a completed conversion.
- AC/AD/AU are registered outputs. They hold the last result through IDLE and the next CONV, and change only on a completion edge or on reset.
- start while busy=1: ignored with no side effect. binIn changes after the accepting edge: no effect.
- start held continuously: a new conversion is accepted on every IDLE edge, giving back-to-back conversions.
- Arithmetic: BCD nibbles are 4 bits each. The hundreds nibble never exceeds 5 for IN_W<=9. No overflow output is required.
- Reset mid-CONV: aborts immediately; outputs return to reset values; no done pulse.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: at completion, leading-zero digits are replaced with ASCII space 7'h20. AC is blank if the hundreds digit is 0. AD is blank if the hundreds and tens digits are both 0. AU always shows a digit. Reset values become AC=AD=7'h20, AU=7'h30.
- Undefined: all three digits are always '0'..'9', and reset values are all 7'h30. Latency and handshake are identical in both builds.

Test Plan:
1. Assert rst_n=0 asynchronously mid-cycle -> busy=0, done=0, AC=AD=AU=7'h30 immediately, without a clock edge.
2. binIn=8'd0, start pulse at edge k -> busy=1 from edge k to edge k+8; done=1 only in the cycle after edge k+8; AC=AD=AU=7'h30.
3. binIn=8'd198 -> AC=7'h31, AD=7'h39, AU=7'h38. Then binIn=8'd255 -> 7'h32, 7'h35, 7'h35. During the second conversion, pulse start with binIn=7 -> ignored; exactly one done; result remains 255.
4. start held high with binIn sweeping 0..255 on each accept -> one done every 9 cycles; every result matches a decimal reference model.
5. binIn=8'd123, start, then rst_n=0 on the 4th CONV cycle -> outputs at reset values, no done. Release reset and repeat -> AC=7'h31, AD=7'h32, AU=7'h33.
6. With LEADING_ZERO_BLANK_EN defined: 7 -> 7'h20, 7'h20, 7'h37; 40 -> 7'h20, 7'h34, 7'h30; 0 -> 7'h20, 7'h20, 7'h30; 105 -> 7'h31, 7'h30, 7'h35.
